display_scheduler: RTL and testbench
====================================

Name: display_scheduler

Overview:
- Shares the 4-digit seven-segment display between NUM_SRC independent requesters.
- Round-robin arbitration with a minimum hold time per grant.
- Latches the granted source's 16-bit value and time-multiplexes it across the four digits: active-low anode select plus the current hex nibble.
- Output feeds the existing hex-to-segment decoder; replaces the ad-hoc display clock divider in top-level counters.

Parameters:
- NUM_SRC, 4: number of requesters, legal range 2..8.
- HOLD_CYCLES, 5_000_000: clk cycles a granted source keeps the display before rotation is considered.
- SCAN_DIV, 50_000: clk cycles per digit scan step.
- IDLE_VALUE, 16'h0000: value shown when nothing is granted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_SRC  level request, bit i = source i.
- src_data  in  16*NUM_SRC  packed; source i occupies [16i+15:16i].
- grant  out  NUM_SRC  one-hot or zero; registered.
- active  out  1  high whenever grant is nonzero.
- annodes  out  4  active-low digit enables; annodes[0] is the least-significant (rightmost) digit.
- nibble  out  4  hex value for the currently enabled digit.
- digit_tick  out  1  one-cycle pulse per scan step.

Behaviour:
- Reset (async assert, sync release): grant=0, active=0, annodes=4'b1111, nibble=0, digit_tick=0.
- Reset also clears: shown value=IDLE_VALUE, scan count=0, digit index=3, rr pointer=NUM_SRC-1 (source 0 wins first), hold count=0, state=IDLE.
- FSM has two states, IDLE and HOLD.
- IDLE, no req: stay; grant=0.
- IDLE, any req in cycle N: winner = first set bit after pointer, circularly. grant is one-hot from cycle N+1; state=HOLD; hold count=0; pointer=winner.
- HOLD: hold count increments each cycle.
- HOLD, granted req bit low: re-arbitrate immediately, no minimum hold. Another req present -> grant moves to the rr winner next cycle. None present -> IDLE, grant=0 next cycle.
- HOLD, hold count reaches HOLD_CYCLES-1 with granted req still high:
  - Another req present -> handover to the rr winner with zero gap: grant goes old->new in one cycle, never two bits set.
  - Only the current source requesting -> keep grant, clear hold count.
- Simultaneous hold expiry and granted-req drop: treated as a drop.
- New requests arriving mid-hold never preempt.
- Shown value: registered every cycle from src_data of the granted source (live tracking, 1-cycle latency). IDLE_VALUE whenever grant=0.
- Scan: scan count runs 0..SCAN_DIV-1 and wraps.
  - At SCAN_DIV-1: digit_tick=1 for one cycle, and digit index = (index+1) mod 4. The first tick after reset selects digit 0.
  - annodes and nibble are registered and update on the same edge as digit_tick rises.
  - annodes = ~(4'b0001 << index); nibble = shown_value[4*index+3 : 4*index].
  - annodes stays 4'b1111 until the first tick.
- Widths: hold and scan counters are sized with $clog2 of their parameters; no truncation at defaults.
- Reset mid-hold or mid-scan returns everything to reset values within the asserting edge. No partial grant survives.

Decomposition:
- Package display_pkg holds:
  - DATA_W=16, NIBBLE_W=4, NUM_DIGITS=4.
  - State enum {IDLE, HOLD}.
  - Function for digit-index to active-low anode mapping.
- Sub-module rr_arbiter: combinational; inputs req and pointer; outputs one-hot winner and any_req. Reused later for other shared peripherals.
- display_scheduler contains the FSM, counters, value register and scan logic.

Test Plan:
All scenarios use NUM_SRC=4, HOLD_CYCLES=8, SCAN_DIV=4, IDLE_VALUE=16'hDEAD.
- Reset/idle: rst_n low then released, req=0.
  - annodes=1111 for 3 cycles.
  - Then digit_tick every 4 cycles; nibbles D,A,E,D on annodes 1110,1101,1011,0111 (digits 0,1,2,3: low to high nibble); grant=0.
- Single source: req=4'b0100, src2=16'h1234.
  - grant=0100 one cycle later; nibble sequence 4,3,2,1.
  - grant held continuously past 8 cycles (hold restarts, no gap).
- Rotation: req=4'b1011 steady.
  - grant order 0001, 0010, 1000, 0001, each lasting exactly 8 cycles.
  - Zero-gap handovers; never two grant bits set.
- Early release: src1 granted, req[1] dropped at hold count 3, req[3] high.
  - grant=1000 on the next cycle; hold count restarts at 0.
- Simultaneous: req[0] drops on the exact hold-expiry cycle, req=4'b0000 otherwise.
  - grant=0 and active=0 next cycle; shown value returns to 16'hDEAD.
- Async reset mid-hold: rst_n pulsed low between clock edges while grant=0010.
  - grant=0 and annodes=1111 immediately.
  - After release with req=4'b0011, source 0 is granted first.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants, FSM state type and digit-to-anode mapping for the display scheduler.
package display_pkg;
   localparam int DATA_W     = 16;
   localparam int NIBBLE_W   = 4;
   localparam int NUM_DIGITS = 4;
   localparam int DIGIT_W    = $clog2(NUM_DIGITS);

   typedef enum logic {IDLE, HOLD} state_t;

   // Active-low one-hot enable for the digit at idx (0 = rightmost).
   function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [DIGIT_W-1:0] idx);
      return ~(NUM_DIGITS'(1) << idx);
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit after ptr, circularly; ptr itself is checked last.
// Zero latency, no backpressure; winner is one-hot or zero.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  winner,
   output logic          any_req
);
   logic [PW-1:0] idx;

   always_comb begin
      winner = '0;
      idx    = '0;
      for (int k = 1; k <= N; k++) begin
         idx = PW'((int'(ptr) + k) % N);
         if (req[idx] && (winner == '0)) winner[idx] = 1'b1;
      end
      any_req = |req;
   end
endmodule

// File: rtl/display_scheduler.sv
// Round-robin share of the 4-digit display with minimum hold per grant; grant 1 cycle after req, value 1 more.
// Requesters are never stalled: a source simply waits for its grant; a dropped req releases the display at once.
module display_scheduler
   import display_pkg::*;
#(
   parameter int                NUM_SRC     = 4,
   parameter int                HOLD_CYCLES = 5_000_000,
   parameter int                SCAN_DIV    = 50_000,
   parameter logic [DATA_W-1:0] IDLE_VALUE  = 16'h0000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_SRC-1:0]        req,
   input  logic [DATA_W*NUM_SRC-1:0] src_data,
   output logic [NUM_SRC-1:0]        grant,
   output logic                      active,
   output logic [NUM_DIGITS-1:0]     annodes,
   output logic [NIBBLE_W-1:0]       nibble,
   output logic                      digit_tick
);
   localparam int PW = $clog2(NUM_SRC);
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   state_t               state_q, state_d;
   logic [NUM_SRC-1:0]   grant_q, grant_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [HW-1:0]        hold_q, hold_d;
   logic [DATA_W-1:0]    shown_q, shown_d;
   logic [SW-1:0]        scan_q;
   logic [DIGIT_W-1:0]   digit_q, digit_nxt;
   logic [NUM_DIGITS-1:0] an_q;
   logic [NIBBLE_W-1:0]  nib_q;
   logic                 tick_q;

   logic [NUM_SRC-1:0]   winner;
   logic                 any_req;
   logic [PW-1:0]        win_idx;
   logic [DATA_W-1:0]    sel_data;

   rr_arbiter #(.N(NUM_SRC), .PW(PW)) u_arb (
      .req     (req),
      .ptr     (ptr_q),
      .winner  (winner),
      .any_req (any_req)
   );

   always_comb begin
      win_idx  = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (winner[i])  win_idx  = PW'(i);
         if (grant_q[i]) sel_data = sel_data | src_data[DATA_W*i +: DATA_W];
      end
      shown_d = (|grant_q) ? sel_data : IDLE_VALUE;
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            grant_d = '0;
            hold_d  = '0;
            if (any_req) begin
               state_d = HOLD;
               grant_d = winner;
               ptr_d   = win_idx;
            end
         end
         HOLD: begin
            hold_d = hold_q + 1'b1;
            // A dropped request wins over hold expiry: release without waiting.
            if (!(|(req & grant_q))) begin
               hold_d = '0;
               if (any_req) begin
                  grant_d = winner;
                  ptr_d   = win_idx;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
               // Winner equals the current source when nobody else asks, so the grant just renews.
               hold_d  = '0;
               grant_d = winner;
               ptr_d   = win_idx;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= PW'(NUM_SRC - 1);
         hold_q  <= '0;
         shown_q <= IDLE_VALUE;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         shown_q <= shown_d;
      end
   end

   assign digit_nxt = digit_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_q  <= '0;
         digit_q <= DIGIT_W'(NUM_DIGITS - 1);
         an_q    <= '1;
         nib_q   <= '0;
         tick_q  <= 1'b0;
      end else if (scan_q == SW'(SCAN_DIV - 1)) begin
         scan_q  <= '0;
         digit_q <= digit_nxt;
         an_q    <= anode_sel(digit_nxt);
         nib_q   <= shown_q[{digit_nxt, 2'b00} +: NIBBLE_W];
         tick_q  <= 1'b1;
      end else begin
         scan_q  <= scan_q + 1'b1;
         tick_q  <= 1'b0;
      end
   end

   assign grant      = grant_q;
   assign active     = |grant_q;
   assign annodes    = an_q;
   assign nibble     = nib_q;
   assign digit_tick = tick_q;
endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: reset scan, single source, rotation, early release, simultaneous drop, async reset.
module tb_display_scheduler;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [63:0] src_data;
   logic [3:0]  grant;
   logic        active;
   logic [3:0]  annodes;
   logic [3:0]  nibble;
   logic        digit_tick;

   int n_checks = 0;
   int n_errors = 0;

   logic [3:0] an_tbl   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [3:0] dead_tbl [4] = '{4'hD, 4'hA, 4'hE, 4'hD};
   logic [3:0] s2_tbl   [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
   logic [3:0] rot_tbl  [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
   logic [3:0] sim_tbl  [4] = '{4'h8, 4'h7, 4'hE, 4'hD};

   display_scheduler #(
      .NUM_SRC     (4),
      .HOLD_CYCLES (8),
      .SCAN_DIV    (4),
      .IDLE_VALUE  (16'hDEAD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .src_data   (src_data),
      .grant      (grant),
      .active     (active),
      .annodes    (annodes),
      .nibble     (nibble),
      .digit_tick (digit_tick)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Reset is released on a negedge with req applied; the k-th following negedge sees the k-th posedge.
   task automatic do_reset(input logic [3:0] r);
      @(negedge clk);
      rst_n = 1'b0;
      req   = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
      req   = r;
   endtask

   initial begin
      rst_n    = 1'b1;
      req      = 4'b0000;
      src_data = {16'hC3C3, 16'h1234, 16'hB1B1, 16'h5678};
      #2 rst_n = 1'b0;

      // Reset values
      step();
      check_eq("rst_grant",  32'(grant), 32'h0);
      check_eq("rst_active", 32'(active), 32'h0);
      check_eq("rst_anodes", 32'(annodes), 32'hF);
      check_eq("rst_nibble", 32'(nibble), 32'h0);
      check_eq("rst_tick",   32'(digit_tick), 32'h0);

      // Idle scan shows DEAD digit by digit
      do_reset(4'b0000);
      for (int d = 0; d < 4; d++) begin
         for (int k = 0; k < 3; k++) begin
            step();
            check_eq("idle_notick", 32'(digit_tick), 32'h0);
            if (d == 0) check_eq("idle_blank", 32'(annodes), 32'hF);
         end
         step();
         check_eq("idle_tick",   32'(digit_tick), 32'h1);
         check_eq("idle_anodes", 32'(annodes), 32'(an_tbl[d]));
         check_eq("idle_nibble", 32'(nibble), 32'(dead_tbl[d]));
         check_eq("idle_grant",  32'(grant), 32'h0);
      end

      // Single source keeps the display across hold expiries
      do_reset(4'b0100);
      for (int k = 1; k <= 16; k++) begin
         step();
         check_eq("single_grant",  32'(grant), 32'h4);
         check_eq("single_active", 32'(active), 32'h1);
         if (k % 4 == 0) begin
            check_eq("single_anodes", 32'(annodes), 32'(an_tbl[k/4-1]));
            check_eq("single_nibble", 32'(nibble), 32'(s2_tbl[k/4-1]));
         end
      end

      // Rotation over 1011, 8 cycles each, zero gap
      do_reset(4'b1011);
      for (int k = 1; k <= 32; k++) begin
         step();
         check_eq("rot_grant",  32'(grant), 32'(rot_tbl[(k-1)/8]));
         check_eq("rot_onehot", 32'($countones(grant) <= 1), 32'h1);
      end

      // Early release at hold count 3, then full hold for the new owner
      do_reset(4'b1010);
      for (int k = 1; k <= 4; k++) begin
         step();
         check_eq("early_src1", 32'(grant), 32'h2);
      end
      req = 4'b1000;
      step();
      check_eq("early_handover", 32'(grant), 32'h8);
      req = 4'b1001;
      for (int k = 6; k <= 12; k++) begin
         step();
         check_eq("early_hold", 32'(grant), 32'h8);
      end
      step();
      check_eq("early_rotate", 32'(grant), 32'h1);

      // Drop coinciding with hold expiry goes idle; shown value returns to DEAD
      do_reset(4'b0001);
      for (int k = 1; k <= 8; k++) begin
         step();
         check_eq("sim_grant", 32'(grant), 32'h1);
         if (k % 4 == 0) check_eq("sim_nibble", 32'(nibble), 32'(sim_tbl[k/4-1]));
      end
      check_eq("sim_active_hi", 32'(active), 32'h1);
      req = 4'b0000;
      for (int k = 9; k <= 16; k++) begin
         step();
         check_eq("sim_grant0", 32'(grant), 32'h0);
         check_eq("sim_active", 32'(active), 32'h0);
         if (k % 4 == 0) check_eq("sim_nibble", 32'(nibble), 32'(sim_tbl[k/4-1]));
      end

      // Async reset between edges while source 1 holds
      do_reset(4'b0010);
      for (int k = 1; k <= 5; k++) step();
      check_eq("ar_pre_grant",  32'(grant), 32'h2);
      check_eq("ar_pre_anodes", 32'(annodes), 32'hE);
      #2 rst_n = 1'b0;
      #1;
      check_eq("ar_grant",  32'(grant), 32'h0);
      check_eq("ar_active", 32'(active), 32'h0);
      check_eq("ar_anodes", 32'(annodes), 32'hF);
      check_eq("ar_nibble", 32'(nibble), 32'h0);
      check_eq("ar_tick",   32'(digit_tick), 32'h0);
      req = 4'b0011;
      step();
      rst_n = 1'b1;
      step();
      check_eq("ar_first", 32'(grant), 32'h1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
